// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Items shared by the UART transmitter and receiver:
//   - uart_state_e   : frame sequencer states (IDLE, START, DATA, PARITY, STOP)
//   - DATA_WIDTH_DEF : default number of data bits per frame
//   - PARITY_EVEN / PARITY_ODD : encodings of the parity_type input
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_parity_calc.sv
// -----------------------------------------------------------------------------
// uart_tx_parity_calc
// Purely combinational parity generator working on the word that the
// transmitter latched at frame acceptance.
//   i_data        [DATA_WIDTH-1:0] latched data word
//   i_parity_type                  PARITY_EVEN (0) or PARITY_ODD (1)
//   o_parity                       parity bit to place on the line
// Even parity makes the total count of ones (data + parity) even, which is
// the XOR-reduction of the data; odd parity is its complement.
// -----------------------------------------------------------------------------
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_parity_type,
    output logic                  o_parity
);

    assign o_parity = (i_parity_type == PARITY_ODD) ? ~^i_data : ^i_data;

endmodule : uart_tx_parity_calc

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Frame serializer: start bit (0), DATA_WIDTH data bits LSB first, optional
// parity bit, stop bit (1). One bit period per CLK cycle.
//
// Ports
//   CLK            transmit bit clock
//   RST            synchronous, active-high reset
//   P_DATA         [DATA_WIDTH-1:0] word to transmit
//   Data_Valid     request; accepted only in IDLE or in the STOP cycle
//   parity_enable  1 = append a parity bit (latched with the word)
//   parity_type    PARITY_EVEN (0) / PARITY_ODD (1) (latched with the word)
//   TX_OUT         serial line, idle high, registered
//   busy           frame in progress, registered
//
// Configuration
//   UART_TX_PARITY_EN : when defined, the PARITY state and parity path are
//   built. When undefined, parity_enable/parity_type are ignored and every
//   frame is DATA_WIDTH+2 cycles.
//
// Timing: the state register advances on the accepting edge N; TX_OUT/busy
// are registered copies of the current state's line value, so the start bit
// appears at edge N+1 and the line trails the state by one cycle.
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    uart_state_e             r_state;
    logic                    r_tx;
    logic                    r_busy;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   r_data;

    uart_state_e             w_state_next;
    logic                    w_tx_next;
    logic                    w_busy_next;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [DATA_WIDTH-1:0]   w_shift_next;
    logic                    w_accept;
    logic                    w_parity_bit;
    logic                    w_parity_type;

`ifdef UART_TX_PARITY_EN
    logic                    r_parity_en;
    logic                    r_parity_type;

    assign w_parity_type = r_parity_type;
`else
    logic                    w_unused_cfg;

    // Parity is not part of the frame in this build; the configuration
    // inputs and the generator output are intentionally left without a load.
    assign w_parity_type = PARITY_EVEN;
    assign w_unused_cfg  = ^{parity_enable, parity_type, w_parity_bit};
`endif

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .i_data        (r_data),
        .i_parity_type (w_parity_type),
        .o_parity      (w_parity_bit)
    );

    // -------------------------------------------------------------------------
    // Next-state and next-line logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b1;
        w_cnt_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_accept     = 1'b0;

        case (r_state)
            IDLE: begin
                w_busy_next = 1'b0;
                if (Data_Valid) begin
                    w_accept     = 1'b1;
                    w_state_next = START;
                end
            end

            START: begin
                w_tx_next    = 1'b0;
                w_cnt_next   = '0;
                w_state_next = DATA;
            end

            DATA: begin
                w_tx_next    = r_shift[0];
                w_shift_next = r_shift >> 1;
                if (r_bit_cnt == LAST_BIT) begin
                    w_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                    w_state_next = r_parity_en ? PARITY : STOP;
`else
                    w_state_next = STOP;
`endif
                end else begin
                    w_cnt_next = r_bit_cnt + CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_tx_next    = w_parity_bit;
                w_state_next = STOP;
            end
`endif

            STOP: begin
                w_tx_next = 1'b1;
                // A request in the stop cycle chains straight into the next
                // start bit with no idle gap.
                if (Data_Valid) begin
                    w_accept     = 1'b1;
                    w_state_next = START;
                end else begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_accept) begin
            w_shift_next = P_DATA;
        end
    end

    // -------------------------------------------------------------------------
    // State, datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (RST) begin
            // NOTE: the shift and data registers are reset along with the FSM
            // so an aborted frame leaves no stale word behind.
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
            r_bit_cnt <= w_cnt_next;
            r_shift   <= w_shift_next;
            if (w_accept) begin
                r_data <= P_DATA;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_parity_en   <= 1'b0;
            r_parity_type <= PARITY_EVEN;
        end else if (w_accept) begin
            r_parity_en   <= parity_enable;
            r_parity_type <= parity_type;
        end
    end
`endif

    assign TX_OUT = r_tx;
    assign busy   = r_busy;

endmodule : uart_tx
